// File: rtl/pkt_buffer_if.sv
// Ingress beat stream, FWFT packet head and fill status of pkt_buffer.
// The DUT takes the slave view; the environment driving it takes the master view.
interface pkt_buffer_if #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int DEPTH_LOG2         = 5
);
    logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser;
    logic                           s_axis_tvalid;
    logic                           s_axis_tlast;
    logic                           s_axis_tready;

    logic [C_AXIS_DATA_WIDTH-1:0]   pkt_fifo_tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0] pkt_fifo_tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0]  pkt_fifo_tuser;
    logic                           pkt_fifo_tlast;
    logic                           pkt_fifo_empty;
    logic                           pkt_fifo_rd_en;

    logic [DEPTH_LOG2:0]            occupancy;
    logic [DEPTH_LOG2:0]            pkt_cnt;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output pkt_fifo_tdata, pkt_fifo_tkeep, pkt_fifo_tuser, pkt_fifo_tlast, pkt_fifo_empty,
        input  pkt_fifo_rd_en,
        output occupancy, pkt_cnt
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  pkt_fifo_tdata, pkt_fifo_tkeep, pkt_fifo_tuser, pkt_fifo_tlast, pkt_fifo_empty,
        output pkt_fifo_rd_en,
        input  occupancy, pkt_cnt
    );
endinterface

// File: rtl/pkt_buffer.sv
// Store-and-forward packet FIFO with first-word-fall-through head. It only
// reports non-empty once a whole packet is stored, or when full (oversize escape).
module pkt_buffer #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int DEPTH_LOG2         = 5
) (
    input  logic         clk,
    input  logic         areset,
    pkt_buffer_if.slave  bus
);
    localparam int DW    = C_AXIS_DATA_WIDTH;
    localparam int KW    = C_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_AXIS_TUSER_WIDTH;
    localparam int EW    = DW + KW + UW + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [EW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   occ_q, occ_d;
    logic [DEPTH_LOG2:0]   pkt_cnt_q, pkt_cnt_d;

    logic          tready;
    logic          wr_en;
    logic          rd_fire;
    logic [EW-1:0] head;

    assign tready  = !areset && (occ_q != FULL_CNT);
    assign wr_en   = bus.s_axis_tvalid && tready;
    // A pop on an empty buffer is dropped even if a write lands this cycle.
    assign rd_fire = !areset && bus.pkt_fifo_rd_en && (occ_q != '0);
    assign head    = mem_q[rd_ptr_q];

    // Storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= {bus.s_axis_tdata, bus.s_axis_tkeep,
                                bus.s_axis_tuser, bus.s_axis_tlast};
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        pkt_cnt_d = pkt_cnt_q;
        if (areset) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            occ_d     = '0;
            pkt_cnt_d = '0;
        end else begin
            if (wr_en)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_en, rd_fire})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            case ({wr_en && bus.s_axis_tlast, rd_fire && head[0]})
                2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
                2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
                default: pkt_cnt_d = pkt_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign bus.s_axis_tready = tready;
    assign {bus.pkt_fifo_tdata, bus.pkt_fifo_tkeep,
            bus.pkt_fifo_tuser, bus.pkt_fifo_tlast} = head;
    // When full with no complete packet, open the head so an oversize packet can drain.
    assign bus.pkt_fifo_empty = (occ_q == '0) ||
                                ((pkt_cnt_q == '0) && (occ_q != FULL_CNT));
    assign bus.occupancy = occ_q;
    assign bus.pkt_cnt   = pkt_cnt_q;
endmodule
